// File: rtl/instr_mem_loader_pkg.sv
// Package: instr_mem_loader_pkg
// Shared definitions for the boot-time instruction memory loader:
// loader FSM state encoding, byte/instruction widths, the default frame
// start marker and the checksum accumulation helper.
package instr_mem_loader_pkg;

   localparam int         BYTE_WIDTH    = 8;
   localparam int         INSTR_WIDTH   = 32;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } loader_state_t;

   // Frame checksum is a plain running XOR of every data byte.
   function automatic logic [BYTE_WIDTH-1:0] csum_update(
      input logic [BYTE_WIDTH-1:0] acc,
      input logic [BYTE_WIDTH-1:0] data
   );
      return acc ^ data;
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Interface: instr_mem_loader_if
// Bundles the byte-stream receive handshake and the instruction memory
// write port of the loader.
//   rx_data/rx_valid/rx_ready : byte stream, transfer = rx_valid & rx_ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write strobe, byte address, word
// Modports: master = loader side, slave = receiver/memory (bench) side.
interface instr_mem_loader_if
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic [BYTE_WIDTH-1:0]  rx_data;
   logic                   rx_valid;
   logic                   rx_ready;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [INSTR_WIDTH-1:0] mem_wdata;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Module: byte_word_packer
// Shifts bytes into a 32-bit big-endian word (first byte ends up in [31:24]).
// A 2-bit byte counter tracks the position; o_word_valid is asserted
// combinationally while the 4th byte is being accepted, with o_word holding
// the completed word in that same cycle.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : drop any partially assembled word
//   i_byte_en      : accept i_byte this cycle
//   o_word_valid   : 4th byte accepted this cycle
//   o_word         : assembled word (valid with o_word_valid)
module byte_word_packer
   import instr_mem_loader_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clear,
   input  logic                   i_byte_en,
   input  logic [BYTE_WIDTH-1:0]  i_byte,
   output logic                   o_word_valid,
   output logic [INSTR_WIDTH-1:0] o_word
);
   logic [23:0] shift_r;
   logic [1:0]  cnt_r;

   // Byte assembly register and position counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         shift_r <= 24'd0;
         cnt_r   <= 2'd0;
      end else if (i_clear) begin
         shift_r <= 24'd0;
         cnt_r   <= 2'd0;
      end else if (i_byte_en) begin
         shift_r <= {shift_r[15:0], i_byte};
         cnt_r   <= cnt_r + 2'd1;
      end else begin
         shift_r <= shift_r;
         cnt_r   <= cnt_r;
      end
   end

   assign o_word_valid = i_byte_en & (cnt_r == 2'd3);
   assign o_word       = {shift_r, i_byte};
endmodule

// File: rtl/instr_mem_loader.sv
// Module: instr_mem_loader
// Boot-time writer for the instruction memory. Receives the frame
//   SYNC_BYTE, N[31:0] big-endian, N*4 data bytes, XOR checksum byte
// packs data bytes big-endian into words and writes them at byte addresses
// 0, 4, 8, ... The CPU is held in reset until the image is loaded and the
// checksum verified.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_restart      : pulse, leaves DONE/ERROR back to IDLE
//   bus            : master side of instr_mem_loader_if (rx handshake + write port)
//   o_cpu_hold     : 1 while not DONE
//   o_done         : image loaded and checksum good (level)
//   o_error        : checksum mismatch or oversize word count (level)
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int         INSTR_ADDR_WIDTH = 32,
   parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEF
)(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_restart,
   instr_mem_loader_if.master  bus,
   output logic                o_cpu_hold,
   output logic                o_done,
   output logic                o_error
);
   // Largest word count that fits the memory; 33 bits so the full 32-bit N compares cleanly.
   localparam logic [32:0] MAX_WORDS = 33'd1 << (INSTR_ADDR_WIDTH - 2);

   loader_state_t              state_r, state_nxt_s;
   logic [31:0]                len_r;
   logic [31:0]                word_cnt_r;
   logic [BYTE_WIDTH-1:0]      csum_r;
   logic                       we_r, ready_r, done_r, error_r, hold_r;
   logic [INSTR_ADDR_WIDTH-1:0] addr_r;
   logic [INSTR_WIDTH-1:0]     wdata_r;

   logic                       xfer_s, pack_en_s, pack_clear_s, word_valid_s;
   logic [INSTR_WIDTH-1:0]     word_s;
   logic                       in_data_s;

   assign xfer_s       = bus.rx_valid & ready_r;
   // The packer also assembles the 4-byte length field.
   assign pack_en_s    = xfer_s & ((state_r == ST_LEN) | (state_r == ST_DATA));
   assign pack_clear_s = ~((state_r == ST_LEN) | (state_r == ST_DATA));
   assign in_data_s    = (state_r == ST_DATA);

   byte_word_packer u_packer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (pack_clear_s),
      .i_byte_en    (pack_en_s),
      .i_byte       (bus.rx_data),
      .o_word_valid (word_valid_s),
      .o_word       (word_s)
   );

   // Next-state logic of the frame parser.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s && (bus.rx_data == SYNC_BYTE)) begin
               state_nxt_s = ST_LEN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LEN: begin
            if (!word_valid_s) begin
               state_nxt_s = ST_LEN;
            end else if (word_s == 32'd0) begin
               state_nxt_s = ST_CHECK;
            end else if ({1'b0, word_s} > MAX_WORDS) begin
               state_nxt_s = ST_ERROR;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_valid_s && ((word_cnt_r + 32'd1) == len_r)) begin
               state_nxt_s = ST_CHECK;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_CHECK: begin
            if (!xfer_s) begin
               state_nxt_s = ST_CHECK;
            end else if (bus.rx_data == csum_r) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (i_restart) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and status flags, the flags registered from the next state.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
         error_r <= 1'b0;
         hold_r  <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s != ST_DONE) && (state_nxt_s != ST_ERROR);
         done_r  <= (state_nxt_s == ST_DONE);
         error_r <= (state_nxt_s == ST_ERROR);
         hold_r  <= (state_nxt_s != ST_DONE);
      end
   end

   // Length, word counter and checksum; cleared whenever the parser is idle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         len_r      <= 32'd0;
         word_cnt_r <= 32'd0;
         csum_r     <= 8'd0;
      end else if (state_r == ST_IDLE) begin
         len_r      <= 32'd0;
         word_cnt_r <= 32'd0;
         csum_r     <= 8'd0;
      end else begin
         if ((state_r == ST_LEN) && word_valid_s) begin
            len_r <= word_s;
         end
         if (in_data_s && word_valid_s) begin
            word_cnt_r <= word_cnt_r + 32'd1;
         end
         if (in_data_s && xfer_s) begin
            csum_r <= csum_update(csum_r, bus.rx_data);
         end
      end
   end

   // Memory write port; address/data hold their last values between strobes.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
      end else begin
         we_r <= in_data_s & word_valid_s;
         if (in_data_s && word_valid_s) begin
            addr_r  <= {word_cnt_r[INSTR_ADDR_WIDTH-3:0], 2'b00};
            wdata_r <= word_s;
         end
      end
   end

   assign bus.rx_ready  = ready_r;
   assign bus.mem_we    = we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = wdata_r;
   assign o_cpu_hold    = hold_r;
   assign o_done        = done_r;
   assign o_error       = error_r;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: a 32-bit-address instance for the main
// scenarios and an 8-bit-address instance for the word-count limit.
// Expected writes and results come from the frame contents themselves.
module tb_instr_mem_loader;
   import instr_mem_loader_pkg::*;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, restart32, restart8;
   logic hold32, done32, err32, hold8, done8, err8;

   instr_mem_loader_if #(.ADDR_W(32)) bus32 ();
   instr_mem_loader_if #(.ADDR_W(8))  bus8 ();

   instr_mem_loader #(.INSTR_ADDR_WIDTH(32), .SYNC_BYTE(8'hA5)) dut32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart32), .bus(bus32.master),
      .o_cpu_hold(hold32), .o_done(done32), .o_error(err32));

   instr_mem_loader #(.INSTR_ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart8), .bus(bus8.master),
      .o_cpu_hold(hold8), .o_done(done8), .o_error(err8));

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got8 = 0;
   logic [7:0]  last_addr8;
   logic [31:0] last_data8;
   logic [31:0] words[$];

   // Write monitors, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus32.mem_we === 1'b1) begin
         got_addr.push_back(bus32.mem_addr);
         got_data.push_back(bus32.mem_wdata);
      end
      if (bus8.mem_we === 1'b1) begin
         got8++;
         last_addr8 = bus8.mem_addr;
         last_data8 = bus8.mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame image of 'words': sync, big-endian count, data, XOR checksum (optionally corrupted).
   function automatic bq_t build_frame(input bit bad);
      bq_t q;
      logic [7:0]  cs = 8'h00;
      logic [31:0] n  = words.size();
      q.push_back(8'hA5);
      for (int k = 3; k >= 0; k--) q.push_back(n[8*k +: 8]);
      foreach (words[i]) begin
         for (int k = 3; k >= 0; k--) begin
            q.push_back(words[i][8*k +: 8]);
            cs = cs ^ words[i][8*k +: 8];
         end
      end
      q.push_back(bad ? (cs ^ 8'h01) : cs);
      return q;
   endfunction

   task automatic send_byte(input bit to8, input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         bus32.rx_valid = 1'b0;
         bus8.rx_valid  = 1'b0;
      end
      @(negedge clk);
      if (to8) begin
         bus8.rx_data = b;  bus8.rx_valid = 1'b1;
      end else begin
         bus32.rx_data = b; bus32.rx_valid = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic send_bytes(input bit to8, input bq_t q, input int count, input int maxgap);
      for (int i = 0; i < count; i++)
         send_byte(to8, q[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      @(negedge clk);
      bus32.rx_valid = 1'b0;
      bus8.rx_valid  = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_load(input string tag, input bit ok);
      check({tag, ".nwrites"}, got_addr.size(), words.size());
      for (int i = 0; i < words.size() && i < got_addr.size(); i++) begin
         check({tag, ".addr"}, got_addr[i], 32'(4 * i));
         check({tag, ".data"}, got_data[i], words[i]);
      end
      check({tag, ".done"},  done32, ok);
      check({tag, ".error"}, err32,  !ok);
      check({tag, ".hold"},  hold32, !ok);
      check({tag, ".ready"}, bus32.rx_ready, 1'b0);
      got_addr.delete();
      got_data.delete();
   endtask

   task automatic do_restart(input bit to8);
      @(negedge clk);
      if (to8) restart8 = 1'b1; else restart32 = 1'b1;
      @(negedge clk);
      restart8 = 1'b0; restart32 = 1'b0;
      if (to8) begin
         check("restart8.ready", bus8.rx_ready, 1'b1);
         check("restart8.error", err8, 1'b0);
      end else begin
         check("restart.ready", bus32.rx_ready, 1'b1);
         check("restart.hold",  hold32, 1'b1);
         check("restart.done",  done32, 1'b0);
         check("restart.error", err32,  1'b0);
      end
   endtask

   initial begin
      bq_t q;
      bit  bad;
      rst_n = 1'b0; restart32 = 1'b0; restart8 = 1'b0;
      bus32.rx_valid = 1'b0; bus32.rx_data = 8'h00;
      bus8.rx_valid  = 1'b0; bus8.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst.we",    bus32.mem_we, 1'b0);
      check("rst.addr",  bus32.mem_addr, 32'd0);
      check("rst.wdata", bus32.mem_wdata, 32'd0);
      check("rst.done",  done32, 1'b0);
      check("rst.error", err32, 1'b0);
      check("rst.hold",  hold32, 1'b1);
      check("rst.ready", bus32.rx_ready, 1'b1);
      check("rst.ready8", bus8.rx_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-word image, good checksum.
      words = '{32'h12345678, 32'h9ABCDEF0};
      q = build_frame(1'b0);
      send_bytes(1'b0, q, q.size(), 0);
      check_load("t1", 1'b1);
      do_restart(1'b0);

      // Same image, corrupted checksum: words still written.
      q = build_frame(1'b1);
      send_bytes(1'b0, q, q.size(), 0);
      check_load("t2", 1'b0);
      do_restart(1'b0);

      // Garbage before sync, then an empty image.
      words.delete();
      q = build_frame(1'b0);
      q.push_front(8'h5A); q.push_front(8'hFF); q.push_front(8'h00);
      send_bytes(1'b0, q, q.size(), 0);
      check_load("t3", 1'b1);
      do_restart(1'b0);

      // Valid gaps, then the same frame continuous.
      words = '{32'h12345678, 32'h9ABCDEF0};
      q = build_frame(1'b0);
      send_bytes(1'b0, q, q.size(), 5);
      check_load("t4.gaps", 1'b1);
      do_restart(1'b0);
      send_bytes(1'b0, q, q.size(), 0);
      check_load("t4.cont", 1'b1);
      do_restart(1'b0);

      // Random images with random gaps and random checksum corruption.
      for (int r = 0; r < 4; r++) begin
         words.delete();
         for (int i = 0; i < int'($urandom_range(8, 1)); i++) words.push_back($urandom);
         bad = 1'($urandom_range(1, 0));
         q = build_frame(bad);
         send_bytes(1'b0, q, q.size(), 3);
         check_load("t4.rand", !bad);
         do_restart(1'b0);
      end

      // Reset after 6 data bytes: one word already written, then a clean reload.
      words = '{32'h12345678, 32'h9ABCDEF0};
      q = build_frame(1'b0);
      send_bytes(1'b0, q, 11, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5.nwrites", got_addr.size(), 1);
      if (got_addr.size() > 0) begin
         check("t5.addr", got_addr[0], 32'd0);
         check("t5.data", got_data[0], 32'h12345678);
      end
      check("t5.done",  done32, 1'b0);
      check("t5.error", err32, 1'b0);
      check("t5.ready", bus32.rx_ready, 1'b1);
      check("t5.hold",  hold32, 1'b1);
      got_addr.delete(); got_data.delete();
      @(negedge clk);
      send_bytes(1'b0, q, q.size(), 0);
      check_load("t5.reload", 1'b1);

      // 8-bit address space: 64 words is the largest legal image.
      words.delete();
      for (int i = 0; i < 64; i++) words.push_back($urandom);
      q = build_frame(1'b0);
      got8 = 0;
      send_bytes(1'b1, q, q.size(), 0);
      check("t6.max.nwrites", got8, 64);
      check("t6.max.lastaddr", last_addr8, 8'hFC);
      check("t6.max.lastdata", last_data8, words[63]);
      check("t6.max.done", done8, 1'b1);
      check("t6.max.hold", hold8, 1'b0);
      do_restart(1'b1);

      // 65 words overflows: error straight after the length field.
      q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h41};
      got8 = 0;
      send_bytes(1'b1, q, q.size(), 0);
      check("t6.over.error", err8, 1'b1);
      check("t6.over.done",  done8, 1'b0);
      check("t6.over.hold",  hold8, 1'b1);
      check("t6.over.ready", bus8.rx_ready, 1'b0);
      check("t6.over.nwrites", got8, 0);
      do_restart(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
